// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus for fetch_sequencer: instruction memory port, decode handshake and redirect.
// The sequencer takes the master modport.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 8
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a combinational instruction memory,
// buffers {instr, pc} in a 2-entry FIFO for decode, with start, redirect/flush and halt-on-opcode.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    fetch_sequencer_if.master bus,
    output logic              halted,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [1:0]         count;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];

    logic pop;
    logic push;
    logic halt_hit;

    assign pop      = (count != 2'd0) && bus.out_ready;
    assign push     = (state == FETCH) && ((count != 2'd2) || pop);
    assign halt_hit = (bus.imem_instr[INSTR_W-1 -: 4] == HALT_OP);

    assign bus.imem_addr = pc;
    assign bus.out_valid = (count != 2'd0);
    // Head is forced to zero when empty so reset and flush leave a clean bus.
    assign bus.out_instr = bus.out_valid ? instr_q[rd_ptr] : '0;
    assign bus.out_pc    = bus.out_valid ? pc_q[rd_ptr]    : '0;

    // Control: state, pc, FIFO pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            halted <= 1'b0;
            busy   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect beats push, pop, halt and start: flush and restart at the target.
            state  <= FETCH;
            pc     <= bus.redirect_pc;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            halted <= 1'b0;
            busy   <= 1'b1;
        end else begin
            if (push) begin
                pc     <= pc + 1'b1;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state  <= FETCH;
                        halted <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (push && halt_hit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Data: FIFO payload, written on push only and never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_instr;
            pc_q[wr_ptr]    <= pc;
        end
    end
endmodule
